proc_bus_responder: RTL and testbench

//  Memory-side responder for the multicycle proc bus (ADDR/DOUT/W out of the CPU, DIN back into it).

---
 rtl/proc_bus_pkg.sv | 32 +++
 rtl/proc_bus_ram.sv | 25 ++
 rtl/proc_bus_responder.sv | 194 +++++++++++++++++++
 tb/tb_proc_bus_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/proc_bus_pkg.sv
// Shared constants for the proc bus responder: region codes, command-bank
// offsets, STATUS bit positions and the line-launch state encoding.
package proc_bus_pkg;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_SW  = 4'h3;
    localparam logic [3:0] REG_CMD = 4'h4;
    localparam logic [3:0] REG_ERR = 4'hF;

    localparam logic [2:0] CMD_X0     = 3'd0;
    localparam logic [2:0] CMD_Y0     = 3'd1;
    localparam logic [2:0] CMD_X1     = 3'd2;
    localparam logic [2:0] CMD_Y1     = 3'd3;
    localparam logic [2:0] CMD_COLOR  = 3'd4;
    localparam logic [2:0] CMD_GO     = 3'd5;
    localparam logic [2:0] CMD_STATUS = 3'd6;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;

    localparam logic [15:0] ERR_ADDR_REG = 16'hF000;
    localparam logic [15:0] ERR_FLAG_REG = 16'hF001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } ld_state_t;

endpackage

// File: rtl/proc_bus_ram.sv
// Word-addressed RAM for the proc bus: asynchronous read so the CPU sees data
// in the same cycle as ADDR, synchronous write. Contents are never reset.
module proc_bus_ram
    import proc_bus_pkg::*;
#(
    parameter int RAM_AW = 7
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [2**RAM_AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/proc_bus_responder.sv
// Memory-side responder for the multicycle proc bus: RAM, LEDs, switches and a
// line-drawer command bank with launch FSM. Define BUS_ERR_EN for error capture.
//
// state | meaning
// IDLE  | engine free, GO write launches
// START | ld_start high for this one cycle
// RUN   | engine drawing, waiting for ld_done
module proc_bus_responder
    import proc_bus_pkg::*;
#(
    parameter int RAM_AW  = 7,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_dout,
    input  logic               i_w,
    output logic [15:0]        o_din,
    input  logic [9:0]         i_sw,
    output logic [9:0]         o_ledr,
    output logic [X_W-1:0]     o_ld_x0,
    output logic [X_W-1:0]     o_ld_x1,
    output logic [Y_W-1:0]     o_ld_y0,
    output logic [Y_W-1:0]     o_ld_y1,
    output logic [COLOR_W-1:0] o_ld_color,
    output logic               o_ld_start,
    input  logic               i_ld_done
);

    logic [3:0]         w_region;
    logic [2:0]         w_off;
    logic [15:0]        w_ram_rdata;
    logic               w_ram_we;
    logic               w_cmd_we;
    logic               w_go;
    logic               w_busy;
    logic               w_done_set;
    logic               w_done_clr;
    logic               w_ovr_clr;
    logic               w_unused;

    logic [9:0]         r_ledr;
    logic [X_W-1:0]     r_x0, r_x1;
    logic [Y_W-1:0]     r_y0, r_y1;
    logic [COLOR_W-1:0] r_color;
    logic               r_done;
    logic               r_ovr;
    ld_state_t          r_state;

    assign w_region   = i_addr[15:12];
    assign w_off      = i_addr[2:0];
    assign w_ram_we   = i_w && (w_region == REG_RAM);
    assign w_cmd_we   = i_w && (w_region == REG_CMD);
    assign w_go       = w_cmd_we && (w_off == CMD_GO) && i_dout[0];
    assign w_busy     = (r_state != IDLE);
    assign w_done_set = w_busy && i_ld_done;
    assign w_done_clr = w_cmd_we && (w_off == CMD_STATUS) && i_dout[STAT_DONE];
    assign w_ovr_clr  = w_cmd_we && (w_off == CMD_STATUS) && i_dout[STAT_OVR];
    assign w_unused   = ^i_addr;

    assign o_ledr     = r_ledr;
    assign o_ld_start = (r_state == START);

    proc_bus_ram #(.RAM_AW(RAM_AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (i_addr[RAM_AW-1:0]),
        .i_wdata (i_dout),
        .o_rdata (w_ram_rdata)
    );

`ifdef BUS_ERR_EN
    logic        w_unmapped;
    logic        r_err;
    logic [15:0] r_erraddr;

    always_comb begin
        w_unmapped = 1'b1;
        if ((w_region == REG_RAM) || (w_region == REG_LED) ||
            (w_region == REG_SW)  || (w_region == REG_CMD) ||
            (i_addr == ERR_ADDR_REG) || (i_addr == ERR_FLAG_REG)) begin
            w_unmapped = 1'b0;
        end
    end

    // First error is held until software clears ERR.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err     <= 1'b0;
            r_erraddr <= '0;
        end else if (i_w && (i_addr == ERR_FLAG_REG)) begin
            r_err <= 1'b0;
        end else if (w_unmapped && !r_err) begin
            r_err     <= 1'b1;
            r_erraddr <= i_addr;
        end
    end
`endif

    always_comb begin
        o_din = '0;
        case (w_region)
            REG_RAM: o_din = w_ram_rdata;
            REG_LED: o_din = {6'b0, r_ledr};
            REG_SW:  o_din = {6'b0, i_sw};
            REG_CMD: begin
                case (w_off)
                    CMD_X0:     o_din = 16'(r_x0);
                    CMD_Y0:     o_din = 16'(r_y0);
                    CMD_X1:     o_din = 16'(r_x1);
                    CMD_Y1:     o_din = 16'(r_y1);
                    CMD_COLOR:  o_din = 16'(r_color);
                    CMD_STATUS: o_din = {13'b0, r_ovr, r_done, w_busy};
                    default:    o_din = '0;
                endcase
            end
`ifdef BUS_ERR_EN
            REG_ERR: begin
                if (i_addr == ERR_ADDR_REG) begin
                    o_din = r_erraddr;
                end else if (i_addr == ERR_FLAG_REG) begin
                    o_din = {15'b0, r_err};
                end
            end
`endif
            default: o_din = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ledr     <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_color    <= '0;
            o_ld_x0    <= '0;
            o_ld_y0    <= '0;
            o_ld_x1    <= '0;
            o_ld_y1    <= '0;
            o_ld_color <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_state    <= IDLE;
        end else begin
            if (i_w && (w_region == REG_LED)) begin
                r_ledr <= i_dout[9:0];
            end
            if (w_cmd_we) begin
                case (w_off)
                    CMD_X0:    r_x0    <= i_dout[X_W-1:0];
                    CMD_Y0:    r_y0    <= i_dout[Y_W-1:0];
                    CMD_X1:    r_x1    <= i_dout[X_W-1:0];
                    CMD_Y1:    r_y1    <= i_dout[Y_W-1:0];
                    CMD_COLOR: r_color <= i_dout[COLOR_W-1:0];
                    default:   ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        o_ld_x0    <= r_x0;
                        o_ld_y0    <= r_y0;
                        o_ld_x1    <= r_x1;
                        o_ld_y1    <= r_y1;
                        o_ld_color <= r_color;
                        r_state    <= START;
                    end
                end
                START:   r_state <= i_ld_done ? IDLE : RUN;
                RUN:     if (i_ld_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Sticky flags: a set in the same cycle as a clear wins.
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end
            if (w_go && w_busy) begin
                r_ovr <= 1'b1;
            end else if (w_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_proc_bus_responder.sv
// Directed bench for proc_bus_responder; the error-capture section is built
// only when BUS_ERR_EN is defined, otherwise 0xF000/0xF001 must read as unmapped.
module tb_proc_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [8:0]  ld_x0, ld_x1;
    logic [7:0]  ld_y0, ld_y1;
    logic [2:0]  ld_color;
    logic        ld_start;
    logic        ld_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    proc_bus_responder dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_addr     (addr),
        .i_dout     (dout),
        .i_w        (w),
        .o_din      (din),
        .i_sw       (sw),
        .o_ledr     (ledr),
        .o_ld_x0    (ld_x0),
        .o_ld_x1    (ld_x1),
        .o_ld_y0    (ld_y0),
        .o_ld_y1    (ld_y1),
        .o_ld_color (ld_color),
        .o_ld_start (ld_start),
        .i_ld_done  (ld_done)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a;
        dout = d;
        w    = 1'b1;
        @(posedge clk);
        #1;
        w = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        @(negedge clk);
        addr = a;
        w    = 1'b0;
        #1;
        check_eq(tag, din, exp);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        ld_done = 1'b1;
        @(posedge clk);
        #1;
        ld_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 16'h0000; dout = 16'h0000; w = 1'b0;
        sw = 10'h000; ld_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_eq("rst_ledr",   16'(ledr), 16'h0000);
        check_eq("rst_start",  16'(ld_start), 16'h0000);
        check_eq("rst_ld_x1",  16'(ld_x1), 16'h0000);
        check_rd("rst_status", 16'h4006, 16'h0000);

        // RAM
        bus_write(16'h0006, 16'h1234);
        bus_write(16'h0005, 16'hBEEF);
        check_rd("ram_rd5",    16'h0005, 16'hBEEF);
        check_rd("ram_rd6",    16'h0006, 16'h1234);
        check_rd("ram_alias",  16'h0085, 16'hBEEF);

        // LEDs, switches, unmapped
        bus_write(16'h1000, 16'hFFFF);
        check_eq("ledr_val",   16'(ledr), 16'h03FF);
        check_rd("ledr_rd",    16'h1000, 16'h03FF);
        sw = 10'h155;
        check_rd("sw_rd",      16'h3000, 16'h0155);
        bus_write(16'h3000, 16'h0000);
        check_rd("sw_ro",      16'h3000, 16'h0155);
        check_rd("unmap_rd",   16'h2000, 16'h0000);

        // Command bank and launch
        bus_write(16'h4000, 16'd5);
        bus_write(16'h4001, 16'd7);
        bus_write(16'h4002, 16'hFFFF);
        check_rd("x1_trunc",   16'h4002, 16'h01FF);
        bus_write(16'h4002, 16'd300);
        bus_write(16'h4003, 16'd200);
        bus_write(16'h4004, 16'hFFFB);
        check_rd("x1_rd",      16'h4002, 16'h012C);
        check_rd("color_rd",   16'h4004, 16'h0003);
        check_rd("go_rd",      16'h4005, 16'h0000);
        check_eq("pre_start",  16'(ld_start), 16'h0000);
        bus_write(16'h4005, 16'h0001);
        check_eq("start_hi",   16'(ld_start), 16'h0001);
        check_eq("ld_x0",      16'(ld_x0), 16'd5);
        check_eq("ld_y0",      16'(ld_y0), 16'd7);
        check_eq("ld_x1",      16'(ld_x1), 16'd300);
        check_eq("ld_y1",      16'(ld_y1), 16'd200);
        check_eq("ld_color",   16'(ld_color), 16'd3);
        check_rd("stat_start", 16'h4006, 16'h0001);
        @(posedge clk);
        #1;
        check_eq("start_lo",   16'(ld_start), 16'h0000);
        check_rd("stat_run",   16'h4006, 16'h0001);

        // Overrun while running
        bus_write(16'h4005, 16'h0001);
        check_eq("ovr_nostart", 16'(ld_start), 16'h0000);
        check_rd("stat_ovr",   16'h4006, 16'h0005);
        bus_write(16'h4000, 16'd9);
        check_eq("x0_hold",    16'(ld_x0), 16'd5);
        pulse_done();
        check_rd("stat_done",  16'h4006, 16'h0006);
        bus_write(16'h4006, 16'h0006);
        check_rd("stat_clr",   16'h4006, 16'h0000);

        // Second launch picks up new X0; DONE set beats a same-cycle clear
        bus_write(16'h4005, 16'h0001);
        check_eq("ld_x0_new",  16'(ld_x0), 16'd9);
        @(posedge clk);
        @(negedge clk);
        addr = 16'h4006; dout = 16'h0002; w = 1'b1; ld_done = 1'b1;
        @(posedge clk);
        #1;
        w = 1'b0; ld_done = 1'b0;
        check_rd("set_wins",   16'h4006, 16'h0002);

        // Reset while running
        bus_write(16'h4005, 16'h0001);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mrst_start", 16'(ld_start), 16'h0000);
        check_eq("mrst_x0",    16'(ld_x0), 16'h0000);
        check_eq("mrst_x1",    16'(ld_x1), 16'h0000);
        check_eq("mrst_color", 16'(ld_color), 16'h0000);
        check_eq("mrst_ledr",  16'(ledr), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        check_rd("mrst_stat",  16'h4006, 16'h0000);
        pulse_done();
        check_rd("late_done",  16'h4006, 16'h0000);
        check_rd("ram_kept",   16'h0005, 16'hBEEF);

`ifdef BUS_ERR_EN
        check_rd("err_init",   16'hF001, 16'h0000);
        check_rd("err_rd",     16'h7123, 16'h0000);
        check_rd("erraddr",    16'hF000, 16'h7123);
        check_rd("err_set",    16'hF001, 16'h0001);
        check_rd("err_rd2",    16'h8000, 16'h0000);
        check_rd("erraddr_kp", 16'hF000, 16'h7123);
        bus_write(16'hF001, 16'h0000);
        check_rd("err_clr",    16'hF001, 16'h0000);
`else
        check_rd("f000_unmap", 16'hF000, 16'h0000);
        check_rd("f001_unmap", 16'hF001, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
